// File: rtl/tf_pkg.sv
// rtl/tf_pkg.sv - shared widths and request/tag types for the transform scheduler
package tf_pkg;
   localparam int TF_X_W   = 11;
   localparam int TF_Y_W   = 10;
   localparam int TF_DIM_W = 11;
   localparam int TF_CV_W  = 13;
   localparam int TF_ID_W  = 3;

   typedef struct packed {
      logic [TF_X_W-1:0]   x;
      logic [TF_Y_W-1:0]   y;
      logic [TF_DIM_W-1:0] w;
      logic [TF_DIM_W-1:0] h;
   } tf_req_t;

   typedef struct packed {
      logic               valid;
      logic [TF_ID_W-1:0] id;
   } tf_tag_t;
endpackage

// File: rtl/tf_rr_arbiter.sv
// rtl/tf_rr_arbiter.sv - combinational round-robin pick starting after the pointer
module tf_rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   pointer,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   index,
   output logic            found
);
   logic [IW-1:0] cand;

   // scan pointer+1 .. pointer (wrapping) and take the first active requester
   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = IW'((int'(pointer) + i) % NREQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            index       = cand;
         end
      end
   end
endmodule

// File: rtl/tf_sched.sv
// rtl/tf_sched.sv - round-robin sharing of one transform unit; TF_SCHED_STATS_EN adds grant/drop counters
module tf_sched
   import tf_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int TF_LAT = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [TF_X_W*NREQ-1:0]     req_x,
   input  logic [TF_Y_W*NREQ-1:0]     req_y,
   input  logic [TF_DIM_W*NREQ-1:0]   req_w,
   input  logic [TF_DIM_W*NREQ-1:0]   req_h,
   output logic [TF_X_W-1:0]          tf_x,
   output logic [TF_Y_W-1:0]          tf_y,
   output logic [TF_DIM_W-1:0]        tf_width,
   output logic [TF_DIM_W-1:0]        tf_height,
   input  logic [TF_CV_W-1:0]         tf_cv_x,
   input  logic [TF_CV_W-1:0]         tf_cv_y,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [TF_CV_W-1:0]         rsp_cv_x,
   output logic [TF_CV_W-1:0]         rsp_cv_y,
   output logic                       busy
`ifdef TF_SCHED_STATS_EN
   ,
   output logic [16*NREQ-1:0]         grant_cnt,
   output logic [15:0]                drop_cnt
`endif
);
   localparam int IW = $clog2(NREQ);

   logic [IW-1:0]   ptr;
   logic [NREQ-1:0] arb_grant;
   logic [IW-1:0]   arb_idx;
   logic            arb_found;
   logic            xfer;
   tf_req_t         reqs [NREQ];
   tf_req_t         sel;
   tf_tag_t         tags [TF_LAT+1];
   logic [3:0]      n_inflight;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign reqs[g] = '{x: req_x[g*TF_X_W +: TF_X_W],
                         y: req_y[g*TF_Y_W +: TF_Y_W],
                         w: req_w[g*TF_DIM_W +: TF_DIM_W],
                         h: req_h[g*TF_DIM_W +: TF_DIM_W]};
   end

   tf_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req     (req_valid),
      .pointer (ptr),
      .grant   (arb_grant),
      .index   (arb_idx),
      .found   (arb_found)
   );

   // flush blocks new work so nothing enters a pipeline that is being emptied
   assign req_ready = (flush || !reset_n) ? '0 : arb_grant;
   assign xfer      = arb_found & ~flush;
   assign sel       = reqs[arb_idx];

   // launch the granted request into the transform and remember who went last
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tf_x      <= '0;
         tf_y      <= '0;
         tf_width  <= '0;
         tf_height <= '0;
         ptr       <= IW'(NREQ - 1);
      end else if (xfer) begin
         tf_x      <= sel.x;
         tf_y      <= sel.y;
         tf_width  <= sel.w;
         tf_height <= sel.h;
         ptr       <= arb_idx;
      end
   end

   // owner tags ride alongside the transform latency; flush empties every stage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n || flush) begin
         for (int i = 0; i <= TF_LAT; i++) tags[i] <= '0;
      end else begin
         tags[0] <= '{valid: xfer, id: xfer ? TF_ID_W'(arb_idx) : '0};
         for (int i = 1; i <= TF_LAT; i++) tags[i] <= tags[i-1];
      end
   end

   // capture the transform result as its tag leaves the last stage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid <= '0;
         rsp_cv_x  <= '0;
         rsp_cv_y  <= '0;
      end else begin
         rsp_valid <= '0;
         if (tags[TF_LAT].valid && !flush) begin
            rsp_valid <= NREQ'(1) << tags[TF_LAT].id;
            rsp_cv_x  <= tf_cv_x;
            rsp_cv_y  <= tf_cv_y;
         end
      end
   end

   // count live tags; busy is simply "any live"
   always_comb begin
      n_inflight = '0;
      for (int i = 0; i <= TF_LAT; i++) n_inflight = n_inflight + {3'b000, tags[i].valid};
   end
   assign busy = (n_inflight != '0);

`ifdef TF_SCHED_STATS_EN
   logic [15:0] gcnt [NREQ];
   logic [16:0] drop_sum;

   assign drop_sum = {1'b0, drop_cnt} + {13'b0, n_inflight};

   for (genvar g = 0; g < NREQ; g++) begin : g_cnt_out
      assign grant_cnt[g*16 +: 16] = gcnt[g];
   end

   // saturating statistics; flush discards tags but never clears the counts
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREQ; i++) gcnt[i] <= '0;
         drop_cnt <= '0;
      end else begin
         if (xfer && gcnt[arb_idx] != 16'hFFFF) gcnt[arb_idx] <= gcnt[arb_idx] + 16'd1;
         if (flush) drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end
`endif
endmodule
